// File: rtl/ram8.sv
// 8 x 16-bit register-file RAM with DMux8Way write decode and Mux8Way16 read.
// Define RAM8_OUT_REG_EN for a registered (1-cycle latency) read port.
module ram8 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out
);

  logic [7:0]       word_load;
  logic [7:0][15:0] word;
  logic [15:0]      rd_mux;

  always_comb begin
    word_load = '0;
    word_load[address] = load;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
    end else begin
      for (int w = 0; w < 8; w++) begin
        word[w] <= word_load[w] ? in : word[w];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      3'd0: rd_mux = word[0];
      3'd1: rd_mux = word[1];
      3'd2: rd_mux = word[2];
      3'd3: rd_mux = word[3];
      3'd4: rd_mux = word[4];
      3'd5: rd_mux = word[5];
      3'd6: rd_mux = word[6];
      3'd7: rd_mux = word[7];
      default: rd_mux = '0;
    endcase
  end

`ifdef RAM8_OUT_REG_EN
  // Captures pre-edge word contents, so a write shows up one edge later.
  logic [15:0] out_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_mux;
    end
  end

  assign out = out_q;
`else
  assign out = rd_mux;
`endif

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: randomized traffic against an array model.
// Works in both read-path builds (RAM8_OUT_REG_EN defined or not).
module tb_ram8;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int tests;
  int fails;

  logic [15:0] mem [8];

  ram8 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
  endtask

  // Present an address for reading; registered build needs one idle edge.
  task automatic rd(input logic [2:0] a);
    load = 1'b0;
    address = a;
`ifdef RAM8_OUT_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    mem[a] = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load = 1'b1;
    in = 16'hFFFF;
    address = 3'd0;
    clear_model();
    #2;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      tick();
      tests++;
      if (out !== 16'h0000) begin
        fails++;
        $display("FAIL reset_out addr=%0d got=%h want=0000", a, out);
      end
    end
    load = 1'b0;
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0]);
      tests++;
      if (out !== 16'h0000) begin
        fails++;
        $display("FAIL reset_ignore_write addr=%0d got=%h want=0000", a, out);
      end
    end
  endtask

  task automatic test_write_all();
    for (int n = 0; n < 8; n++) wr(n[2:0], 16'(16'h1111 * (n + 1)));
    for (int n = 0; n < 8; n++) begin
      rd(n[2:0]);
      tests++;
      if (out !== 16'(16'h1111 * (n + 1))) begin
        fails++;
        $display("FAIL write_all addr=%0d got=%h want=%h",
                 n, out, 16'(16'h1111 * (n + 1)));
      end
    end
  endtask

  task automatic test_hold();
    load = 1'b0;
    in = 16'hFFFF;
    for (int n = 0; n < 8; n++) begin
      address = n[2:0];
      tick();
    end
    for (int n = 0; n < 8; n++) begin
      rd(n[2:0]);
      tests++;
      if (out !== mem[n]) begin
        fails++;
        $display("FAIL hold addr=%0d got=%h want=%h", n, out, mem[n]);
      end
    end
  endtask

`ifdef RAM8_OUT_REG_EN
  task automatic test_registered_read();
    logic [15:0] old;
    rd(3'd2);
    old = mem[2];
    address = 3'd2;
    in = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    mem[2] = 16'h1234;
    tests++;
    if (out !== old) begin
      fails++;
      $display("FAIL reg_read_edge_k got=%h want=%h", out, old);
    end
    tick();
    tests++;
    if (out !== 16'h1234) begin
      fails++;
      $display("FAIL reg_read_edge_k1 got=%h want=1234", out);
    end
  endtask
`else
  task automatic test_same_addr();
    wr(3'd3, 16'h0444);
    address = 3'd3;
    in = 16'hBEEF;
    load = 1'b1;
    #1;
    tests++;
    if (out !== 16'h0444) begin
      fails++;
      $display("FAIL same_addr_before got=%h want=0444", out);
    end
    tick();
    load = 1'b0;
    mem[3] = 16'hBEEF;
    tests++;
    if (out !== 16'hBEEF) begin
      fails++;
      $display("FAIL same_addr_after got=%h want=beef", out);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] pre;
    logic [15:0] exp;
    logic [2:0]  a;
    logic        l;
    logic [15:0] d;
    for (int i = 0; i < 300; i++) begin
      a = 3'($urandom_range(0, 7));
      l = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      // Glitch load/in mid-cycle; only the values at the edge may count.
      if ($urandom_range(0, 3) == 0) begin
        address = a;
        load = 1'b1;
        in = ~d;
        #2;
      end
      address = a;
      load = l;
      in = d;
      tick();
      pre = mem[a];
      if (l) mem[a] = d;
`ifdef RAM8_OUT_REG_EN
      exp = pre;
`else
      exp = mem[a];
`endif
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL random i=%0d addr=%0d load=%0d got=%h want=%h",
                 i, a, l, out, exp);
      end
    end
    load = 1'b0;
    for (int n = 0; n < 8; n++) begin
      rd(n[2:0]);
      tests++;
      if (out !== mem[n]) begin
        fails++;
        $display("FAIL random_final addr=%0d got=%h want=%h", n, out, mem[n]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    wr(3'd5, 16'h1357);
    rd(3'd5);
    address = 3'd5;
    in = 16'h5A5A;
    load = 1'b1;
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    tests++;
    if (out !== 16'h0000) begin
      fails++;
      $display("FAIL reset_mid_write_async got=%h want=0000", out);
    end
    tick();
    load = 1'b0;
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rd(n[2:0]);
      tests++;
      if (out !== 16'h0000) begin
        fails++;
        $display("FAIL reset_mid_write_clear addr=%0d got=%h want=0000",
                 n, out);
      end
    end
  endtask

  task automatic test_first_write();
    reset_n = 1'b0;
    clear_model();
    address = 3'd6;
    in = 16'hC0DE;
    load = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    load = 1'b0;
    mem[6] = 16'hC0DE;
    rd(3'd6);
    tests++;
    if (out !== 16'hC0DE) begin
      fails++;
      $display("FAIL first_write got=%h want=c0de", out);
    end
    rd(3'd7);
    tests++;
    if (out !== 16'h0000) begin
      fails++;
      $display("FAIL first_write_neighbour got=%h want=0000", out);
    end
  endtask

  task automatic test_boundary();
    wr(3'd7, 16'hFFFF);
    wr(3'd0, 16'h0001);
    for (int n = 0; n < 8; n++) begin
      rd(n[2:0]);
      tests++;
      if (out !== mem[n]) begin
        fails++;
        $display("FAIL boundary addr=%0d got=%h want=%h", n, out, mem[n]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    in = '0;
    load = 1'b0;
    address = '0;
    reset_n = 1'b0;
    test_reset();
    test_write_all();
    test_hold();
`ifdef RAM8_OUT_REG_EN
    test_registered_read();
`else
    test_same_addr();
`endif
    test_boundary();
    test_random();
    test_reset_mid_write();
    test_first_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
